// File: rtl/filter_apb_pkg.sv
// Shared definitions for the image-filter coefficient bank: register map,
// CTRL bit positions and the bus-side FSM state encoding.
package filter_apb_pkg;

  localparam int unsigned CTRL_OFF     = 32'h000;
  localparam int unsigned STATUS_OFF   = 32'h004;
  localparam int unsigned SHADOW_BASE  = 32'h010;
  localparam int unsigned ACTIVE_BASE  = 32'h080;

  localparam int unsigned CTRL_COMMIT    = 0;
  localparam int unsigned CTRL_IMMEDIATE = 1;

  localparam int unsigned MAX_NUM_COEF = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_fsm_wait.sv
// APB completer handshake: IDLE/SETUP/ACCESS sequencing with a programmable
// wait-state counter; emits a one-cycle xfer_done and the latched request.
module apb_fsm_wait
  import filter_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_W      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]     pstrb,
  output logic                  xfer_done,
  output logic [ADDR_WIDTH-1:0] lat_addr,
  output logic [DATA_WIDTH-1:0] lat_wdata,
  output logic [STRB_W-1:0]     lat_strb,
  output logic                  lat_write
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  apb_state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       setup_hit;

  assign setup_hit = (state == ST_IDLE) && psel && !penable;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      lat_write <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (setup_hit) begin
        lat_addr  <= paddr;
        lat_wdata <= pwdata;
        lat_strb  <= pstrb;
        lat_write <= pwrite;
      end
    end
  end

  // SETUP is the first access-phase cycle, so a zero count completes there
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    xfer_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (setup_hit) begin
          state_nx = ST_SETUP;
          cnt_nx   = WAIT_INIT;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!psel) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt != 3'd0) begin
          cnt_nx   = cnt - 3'd1;
          state_nx = ST_ACCESS;
        end else if (penable) begin
          xfer_done = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/apb_coef_regfile.sv
// Double-buffered APB3 coefficient bank: shadow written over APB, active bank
// swapped in on a frame boundary (or immediately). Optional APB_PSTRB_EN adds byte strobes.
module apb_coef_regfile
  import filter_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_COEF    = 8,
  parameter int COEF_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ADDR_WIDTH-1:0]          i_PADDR,
  input  logic                           i_PSEL,
  input  logic                           i_PENABLE,
  input  logic                           i_PWRITE,
  input  logic [DATA_WIDTH-1:0]          i_PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        i_PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]          o_PRDATA,
  output logic                           o_PREADY,
  output logic                           o_PSLVERR,
  input  logic                           i_frame_start,
  output logic [NUM_COEF*COEF_WIDTH-1:0] o_coef,
  output logic                           o_commit_pending
);

  localparam int STRB_W = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] sext(input logic signed [COEF_WIDTH-1:0] c);
    sext = DATA_WIDTH'(c);
  endfunction

  function automatic logic signed [COEF_WIDTH-1:0] merge_coef(
    input logic signed [COEF_WIDTH-1:0] old_c,
    input logic [DATA_WIDTH-1:0]        wd,
    input logic [STRB_W-1:0]            st
  );
    merge_coef = old_c;
    for (int b = 0; b < COEF_WIDTH; b++)
      if (st[b/8]) merge_coef[b] = wd[b];
  endfunction

  logic [STRB_W-1:0]     bus_strb;
  logic                  xfer_done;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_W-1:0]     lat_strb;
  logic                  lat_write;

`ifdef APB_PSTRB_EN
  assign bus_strb = i_PSTRB;
`else
  assign bus_strb = '1;
`endif

  apb_fsm_wait #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_W     (STRB_W),
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk      (clk),
    .rstn     (rstn),
    .psel     (i_PSEL),
    .penable  (i_PENABLE),
    .pwrite   (i_PWRITE),
    .paddr    (i_PADDR),
    .pwdata   (i_PWDATA),
    .pstrb    (bus_strb),
    .xfer_done(xfer_done),
    .lat_addr (lat_addr),
    .lat_wdata(lat_wdata),
    .lat_strb (lat_strb),
    .lat_write(lat_write)
  );

  logic signed [COEF_WIDTH-1:0] shadow [NUM_COEF];
  logic signed [COEF_WIDTH-1:0] active [NUM_COEF];
  logic                         pending;

  logic [31:0]       a32;
  logic [31:0]       idx;
  logic              is_ctrl, is_status, in_sh, in_ac, strb_any, err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic              wr_ok, ctrl_wr, imm_swap, arm, do_swap, sh_wr;
  logic              unused_wdata;

  assign unused_wdata = ^lat_wdata;

  // Decode the latched request; a write with no strobe lanes is a silent no-op
  always_comb begin
    a32       = 32'(lat_addr);
    is_ctrl   = (a32 == CTRL_OFF);
    is_status = (a32 == STATUS_OFF);
    in_sh     = (a32 >= SHADOW_BASE) && (a32 < SHADOW_BASE + 4 * MAX_NUM_COEF);
    in_ac     = (a32 >= ACTIVE_BASE) && (a32 < ACTIVE_BASE + 4 * MAX_NUM_COEF);
    idx       = in_sh ? ((a32 - SHADOW_BASE) >> 2) : ((a32 - ACTIVE_BASE) >> 2);
    strb_any  = |lat_strb;
    err = (lat_addr[1:0] != 2'b00)
       || !(is_ctrl || is_status || in_sh || in_ac)
       || ((in_sh || in_ac) && (idx >= 32'(NUM_COEF)))
       || (lat_write && (is_status || in_ac));
    if (lat_write && !strb_any) err = 1'b0;
  end

  assign wr_ok    = xfer_done && lat_write && !err && strb_any;
  assign ctrl_wr  = wr_ok && is_ctrl && lat_strb[0];
  assign imm_swap = ctrl_wr && lat_wdata[CTRL_IMMEDIATE];
  assign arm      = ctrl_wr && lat_wdata[CTRL_COMMIT] && !lat_wdata[CTRL_IMMEDIATE];
  assign do_swap  = imm_swap || (pending && i_frame_start);
  assign sh_wr    = wr_ok && in_sh;

  // Swap samples the shadow bank before this cycle's shadow write lands
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (do_swap) begin
        pending <= 1'b0;
        for (int i = 0; i < NUM_COEF; i++) active[i] <= shadow[i];
      end
      if (arm) pending <= 1'b1;
      for (int i = 0; i < NUM_COEF; i++)
        if (sh_wr && (idx == 32'(i))) shadow[i] <= merge_coef(shadow[i], lat_wdata, lat_strb);
    end
  end

  always_comb begin
    rd_val = '0;
    if (is_status) rd_val = DATA_WIDTH'(pending);
    for (int i = 0; i < NUM_COEF; i++) begin
      if (in_sh && (idx == 32'(i))) rd_val = sext(shadow[i]);
      if (in_ac && (idx == 32'(i))) rd_val = sext(active[i]);
    end
  end

  assign o_PREADY         = xfer_done;
  assign o_PSLVERR        = xfer_done && err;
  assign o_PRDATA         = (xfer_done && !lat_write && !err) ? rd_val : '0;
  assign o_commit_pending = pending;

  always_comb begin
    o_coef = '0;
    for (int i = 0; i < NUM_COEF; i++) o_coef[i*COEF_WIDTH +: COEF_WIDTH] = active[i];
  end

endmodule

// File: doc/apb_coef_regfile.md
Name: apb_coef_regfile

Overview:
- Parametrised APB3 completer holding the image-filter coefficient bank. Generalises the fixed 8 x 10-bit weight slave.
- Adds a real PREADY/PSLVERR handshake with programmable wait states, and double-buffered coefficients: shadow registers are written over APB, and active registers feed the filter datapath.
- The shadow→active swap happens only on a frame boundary, so the filter never sees a half-updated bank mid-frame.

Parameters:
- ADDR_WIDTH, 10, PADDR width (byte address; word index = PADDR[ADDR_WIDTH-1:2]).
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 16 or 32.
- NUM_COEF, 8, number of coefficients; legal range 1..28.
- COEF_WIDTH, 10, coefficient width, two's complement; must be ≤ DATA_WIDTH.
- WAIT_STATES, 0, extra access-phase cycles before PREADY; legal range 0..7.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- i_PADDR  in  ADDR_WIDTH  APB address
- i_PSEL  in  1  select
- i_PENABLE  in  1  enable (access phase)
- i_PWRITE  in  1  1 = write
- i_PWDATA  in  DATA_WIDTH  write data
- o_PRDATA  out  DATA_WIDTH  read data; valid when o_PREADY=1
- o_PREADY  out  1  transfer complete
- o_PSLVERR  out  1  error; valid only with o_PREADY=1
- i_frame_start  in  1  one-cycle pulse at the start of each frame
- o_coef  out  NUM_COEF*COEF_WIDTH  active coefficients, coef i at [i*COEF_WIDTH +: COEF_WIDTH]
- o_commit_pending  out  1  a swap is armed

Behaviour:
- Reset: all shadow and active registers = 0; o_PRDATA=0; o_PREADY=0; o_PSLVERR=0; o_commit_pending=0; FSM=IDLE; wait counter=0.
- FSM states:
  - IDLE: PSEL & !PENABLE → SETUP.
  - SETUP: latch address, direction and data; → ACCESS; counter = WAIT_STATES.
  - ACCESS: counter > 0 → decrement; counter = 0 → assert o_PREADY for exactly one cycle and perform the write (or present the read) that cycle → IDLE.
  - PSEL dropped during ACCESS → abort to IDLE with no side effects.
- Latency: PREADY rises in the (WAIT_STATES+1)-th cycle of the access phase. Back-to-back transfers are supported (SETUP may directly follow PREADY).
- Register map (byte offsets):
  - 0x000 CTRL (W): bit0 COMMIT is write-1-to-arm and sets pending; bit1 IMMEDIATE causes the swap at the PREADY cycle instead of waiting for i_frame_start; reads return 0.
  - 0x004 STATUS (RO): bit0 = pending.
  - 0x010+4i COEF_SHADOW[i] (RW): write takes PWDATA[COEF_WIDTH-1:0]; read returns the value sign-extended to DATA_WIDTH.
  - 0x080+4i COEF_ACTIVE[i] (RO): sign-extended readback.
- PSLVERR=1 for: unmapped address, i >= NUM_COEF, write to a RO register, or unaligned PADDR[1:0] != 0. An erroring write has no effect; an erroring read returns 0.
- Swap: when pending and i_frame_start=1, active ← shadow (whole bank in one cycle) and pending ← 0. o_coef changes the cycle after the swap edge.
- Boundary cases:
  - COMMIT write and i_frame_start in the same cycle: pending sets; the swap waits for the next frame_start.
  - Shadow write and swap in the same cycle: the swap copies the pre-write shadow value; the new value stays in shadow.
  - Shadow writes while pending: allowed; the latest value is taken at the swap.
  - Repeated COMMIT while pending: no change.
  - i_frame_start with no pending: no change.
  - IMMEDIATE and COMMIT in one write: immediate swap; pending stays 0.
  - rstn asserted mid-transfer: all state to reset values; the transfer is dropped.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - Adds port i_PSTRB (in, DATA_WIDTH/8), APB4 byte strobes.
  - Shadow writes update only the coefficient bits covered by active strobe lanes.
  - A CTRL write acts only if PSTRB[0]=1.
  - A write with PSTRB all zero completes with no effect and no error.
- Undefined: no port; all bytes are written.

Decomposition:
- Package filter_apb_pkg:
  - register offset constants (CTRL, STATUS, SHADOW_BASE, ACTIVE_BASE);
  - CTRL bit indices;
  - FSM state encoding (IDLE/SETUP/ACCESS);
  - MAX_NUM_COEF=28.
- Sub-module apb_fsm_wait: IDLE/SETUP/ACCESS FSM and wait counter; outputs a one-cycle xfer_done strobe and latched addr/data/dir. The register decode/storage stays in the top.

Test Plan:
- Reset then read 0x010 and 0x080 with WAIT_STATES=2 → PREADY in 3rd access cycle, PRDATA=0, PSLVERR=0, o_coef=0.
- Write 0x3FF to 0x014 and read it back → PRDATA=0xFFFFFFFF (sign-extended −1); o_coef[10+:10] unchanged until commit.
- Write CTRL=0x1 → STATUS=1; pulse i_frame_start → next cycle o_coef[10+:10]=0x3FF, STATUS=0, 0x084 reads 0xFFFFFFFF.
- Write 0x010=0x005 in the same cycle as the i_frame_start swap → active coef0 keeps its old value, shadow=5; next commit+frame → active coef0=5.
- Write 0x030 (i=8, NUM_COEF=8) and write 0x080 → PSLVERR=1, no state change. Read 0x012 → PSLVERR=1, PRDATA=0.
- Assert rstn low during ACCESS of a COEF write → after release shadow=0, PREADY=0, FSM IDLE. With APB_PSTRB_EN, PSTRB=0b0001 write 0x3AB over 0x155 → result 0x1AB.
